pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised successor to the single-cycle program counter register.
- Generates the instruction fetch address with a valid/ready handshake toward the fetch stage.
- Arbitrates trap, jump and hold requests by fixed priority.
- Holds a small return-address stack (RAS) that ex/commit uses for call/return prediction.
- Sits between the ex/ctrl stage (redirect, hold, RAS push/pop) and the ifetch stage (fetch address).

Parameters:
- ADDR_W, 32: width of all instruction addresses.
- RST_ADDR, 32'h0000_0000: PC value loaded on reset.
- INST_BYTES, 4: PC increment per accepted fetch.
- HOLD_W, 3: width of hold_flag_in.
- HOLD_PC, 1: hold_flag_in >= HOLD_PC stalls the PC.
- RAS_DEPTH, 4: RAS entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- trap_flag_in  in  1  trap/interrupt redirect request.
- trap_addr_in  in  ADDR_W  trap vector.
- jump_flag_in  in  1  branch/jump redirect request.
- jump_addr_in  in  ADDR_W  jump target.
- hold_flag_in  in  HOLD_W  pipeline hold level.
- fetch_ready_in  in  1  ifetch accepts pc_out this cycle.
- fetch_valid_out  out  1  pc_out is a valid fetch request.
- pc_out  out  ADDR_W  current fetch address.
- redirect_out  out  1  registered pulse: pc_out was loaded by trap/jump at the last edge (fetch flushes in-flight data).
- ras_push_in  in  1  push ras_push_addr_in (call retired).
- ras_push_addr_in  in  ADDR_W  return address to push.
- ras_pop_in  in  1  pop top entry (return retired).
- ras_top_out  out  ADDR_W  current top of stack; 0 when empty.
- ras_valid_out  out  1  stack non-empty.

Behaviour:
- Reset (rst=0, asynchronous), all outputs:
  - pc_out=RST_ADDR, redirect_out=0, started_q=0, RAS count=0, write pointer=0.
  - fetch_valid_out=0, ras_valid_out=0, ras_top_out=0.
  - RAS entry storage is not reset.
- started_q sets to 1 at the first rising edge after rst deasserts and stays set.
- fetch_valid_out = started_q AND NOT(hold_flag_in >= HOLD_PC). Combinational; no other path.
- fire = fetch_valid_out AND fetch_ready_in.
- PC update priority per rising edge, first match wins:
  - trap_flag_in: pc <= trap_addr_in, redirect_out <= 1.
  - jump_flag_in: pc <= jump_addr_in, redirect_out <= 1.
  - hold_flag_in >= HOLD_PC: pc unchanged, redirect_out <= 0.
  - fire: pc <= pc + INST_BYTES, modulo 2^ADDR_W (wraps 0xFFFF_FFFC -> 0x0 at defaults), redirect_out <= 0.
  - otherwise (valid but not ready): pc unchanged, redirect_out <= 0.
- Redirect beats hold and beats a pending un-accepted fetch. The old address is dropped; fetch_valid_out may stay high across the change. This is the only case where pc_out changes while valid && !ready.
- Redirect targets are loaded unmodified; no alignment check.
- redirect_out is high exactly one cycle per redirect edge. Back-to-back redirects give back-to-back pulses.
- RAS: circular buffer of RAS_DEPTH entries, write pointer wp, count cnt (0..RAS_DEPTH).
  - Push only: entry[wp] <= addr; wp++ (wraps); cnt saturates at RAS_DEPTH. Push when full overwrites the oldest entry.
  - Pop only: if cnt>0, wp--, cnt--. If empty: no-op, no underflow.
  - Push and pop together: entry[wp-1] <= addr; wp and cnt unchanged. When empty, this acts as a push only.
  - trap_flag_in clears cnt to 0 (stack flushed) and overrides any push/pop that cycle. jump_flag_in does not affect the RAS.
  - ras_top_out = entry[wp-1] when cnt>0, else 0. Registered state, combinational read. ras_valid_out = (cnt != 0).
- Reset asserted mid-operation: state returns to reset values immediately, regardless of clk.

Decomposition:
- Shared defines header: RST_ADDR default, INST_BYTES, HOLD_PC level encoding, hold-bus width, reset polarity macro. The active-low reset level constant replaces the old active-high one for this block.
- One sub-module: pc_ras (stack storage, pointer, count, push/pop/flush logic, top read).
- pc_gen contains the PC register, priority mux, started_q, redirect_out, and the handshake.

Test Plan:
- Reset release, ready=1, hold=0 -> fetch_valid_out goes 1 one cycle after release; pc_out = 0x0, 0x4, 0x8 on consecutive cycles.
- ready=0 for 3 cycles at pc=0x8 -> pc_out stays 0x8 and valid stays 1; ready=1 -> 0xC next cycle.
- hold=HOLD_PC with jump_flag_in=1, target 0x100 in the same cycle -> pc_out=0x100, redirect_out pulses 1 for one cycle; with hold kept high, valid=0 and pc stays 0x100.
- trap=1 (0x80) and jump=1 (0x200) simultaneously -> pc_out=0x80, RAS cnt=0.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4) -> top=0x50; 4 pops return 0x50, 0x40, 0x30, 0x20; 5th pop leaves valid=0, top=0.
- Start at pc=0xFFFF_FFFC, fire -> pc_out=0x0. Separately: rst pulsed low mid-cycle -> pc_out=RST_ADDR and valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen shared definitions: reset level, defaults
// and the RAS operation encoding.
package pc_gen_pkg;

    localparam logic        RST_ACTIVE     = 1'b0;
    localparam int          ADDR_W_DEF     = 32;
    localparam logic [31:0] RST_ADDR_DEF   = 32'h0000_0000;
    localparam int          INST_BYTES_DEF = 4;
    localparam int          HOLD_W_DEF     = 3;
    localparam int          HOLD_PC_DEF    = 1;
    localparam int          RAS_DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP,
        RAS_FLUSH
    } ras_op_e;

    // Flush wins; push+pop on an empty stack degrades to push.
    function automatic ras_op_e ras_decode(
        input logic flush,
        input logic push,
        input logic pop,
        input logic nonempty
    );
        if (flush)                       return RAS_FLUSH;
        else if (push && pop && nonempty) return RAS_SWAP;
        else if (push)                   return RAS_PUSH;
        else if (pop && nonempty)        return RAS_POP;
        else                             return RAS_IDLE;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side handshake between pc_gen (master)
// and the ifetch stage (slave).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid_out;
    logic              fetch_ready_in;
    logic [ADDR_W-1:0] pc_out;
    logic              redirect_out;

    modport master (
        input  fetch_ready_in,
        output fetch_valid_out,
        output pc_out,
        output redirect_out
    );

    modport slave (
        output fetch_ready_in,
        input  fetch_valid_out,
        input  pc_out,
        input  redirect_out
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with write
// pointer and saturating count; oldest entry is overwritten.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_addr,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_cnt;

    logic [PTR_W-1:0]  w_wp_m1;
    logic [PTR_W-1:0]  w_wp_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_nonempty;
    ras_op_e           w_op;

    assign w_nonempty = (r_cnt != '0);
    assign w_wp_m1    = r_wp - PTR_W'(1);
    assign w_op       = ras_decode(i_flush, i_push, i_pop, w_nonempty);

    // Next pointer/count for the decoded stack operation.
    always_comb begin
        w_wp_n  = r_wp;
        w_cnt_n = r_cnt;
        unique case (w_op)
            RAS_FLUSH: w_cnt_n = '0;
            RAS_PUSH: begin
                w_wp_n = r_wp + PTR_W'(1);
                if (r_cnt != CNT_W'(DEPTH))
                    w_cnt_n = r_cnt + CNT_W'(1);
            end
            RAS_POP: begin
                w_wp_n  = w_wp_m1;
                w_cnt_n = r_cnt - CNT_W'(1);
            end
            RAS_SWAP: ;
            RAS_IDLE: ;
            default: ;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= w_wp_n;
            r_cnt <= w_cnt_n;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_op == RAS_PUSH)
            r_mem[r_wp] <= i_push_addr;
        else if (w_op == RAS_SWAP)
            r_mem[w_wp_m1] <= i_push_addr;
    end

    assign o_top   = w_nonempty ? r_mem[w_wp_m1] : '0;
    assign o_valid = w_nonempty;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > jump > hold > fire priority,
// registered redirect pulse, and a return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RST_ADDR   = ADDR_W'(RST_ADDR_DEF),
    parameter int                INST_BYTES = INST_BYTES_DEF,
    parameter int                HOLD_W     = HOLD_W_DEF,
    parameter int                HOLD_PC    = HOLD_PC_DEF,
    parameter int                RAS_DEPTH  = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_flag_in,
    input  logic [ADDR_W-1:0] trap_addr_in,
    input  logic              jump_flag_in,
    input  logic [ADDR_W-1:0] jump_addr_in,
    input  logic [HOLD_W-1:0] hold_flag_in,
    pc_gen_if.master          fetch,
    input  logic              ras_push_in,
    input  logic [ADDR_W-1:0] ras_push_addr_in,
    input  logic              ras_pop_in,
    output logic [ADDR_W-1:0] ras_top_out,
    output logic              ras_valid_out
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_redirect;
    logic              r_started;

    logic [ADDR_W-1:0] w_pc_n;
    logic              w_redir_n;
    logic              w_hold;
    logic              w_valid;
    logic              w_fire;

    assign w_hold  = (hold_flag_in >= HOLD_W'(HOLD_PC));
    assign w_valid = r_started & ~w_hold;
    assign w_fire  = w_valid & fetch.fetch_ready_in;

    assign fetch.fetch_valid_out = w_valid;
    assign fetch.pc_out          = r_pc;
    assign fetch.redirect_out    = r_redirect;

    // Priority mux; a redirect may drop an un-accepted fetch.
    always_comb begin
        w_pc_n    = r_pc;
        w_redir_n = 1'b0;
        if (trap_flag_in) begin
            w_pc_n    = trap_addr_in;
            w_redir_n = 1'b1;
        end else if (jump_flag_in) begin
            w_pc_n    = jump_addr_in;
            w_redir_n = 1'b1;
        end else if (w_fire) begin
            w_pc_n = r_pc + ADDR_W'(INST_BYTES);
        end
    end

    // PC, redirect pulse and start-up flag.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_pc       <= RST_ADDR;
            r_redirect <= 1'b0;
            r_started  <= 1'b0;
        end else begin
            r_pc       <= w_pc_n;
            r_redirect <= w_redir_n;
            r_started  <= 1'b1;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (trap_flag_in),
        .i_push      (ras_push_in),
        .i_pop       (ras_pop_in),
        .i_push_addr (ras_push_addr_in),
        .o_top       (ras_top_out),
        .o_valid     (ras_valid_out)
    );

endmodule
